moving_average_rs: RTL and testbench

MOVING_AVERAGE_RS -- requirements
Module: moving_average_rs

---
 rtl/moving_avg_pkg.sv | 24 ++
 rtl/ma_sample_buf.sv | 41 ++++
 rtl/moving_average_rs.sv | 172 +++++++++++++++++
 tb/tb_moving_average_rs.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/moving_avg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : moving_avg_pkg                                          |
// | Purpose    : Shared types and helpers for the moving-average block:  |
// |              controller state encoding and running-sum width.        |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
package moving_avg_pkg;

  // CLR: buffer sweep in progress, no samples accepted.
  // RUN: samples accepted, one average produced per accepted sample.
  typedef enum logic [0:0] {
    CLR = 1'b0,
    RUN = 1'b1
  } state_e;

  // The sum of at most 2^max_pow samples of data_w bits each fits in
  // data_w + max_pow bits, so the running sum can never wrap.
  function automatic int sum_width(input int data_w, input int max_pow);
    return data_w + max_pow;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ma_sample_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : ma_sample_buf                                           |
// | Purpose    : Sample history memory: one synchronous write port and   |
// |              one asynchronous read port. No reset; contents are      |
// |              cleared by the owner writing zeros.                     |
// | Ports      : clk    - write clock                                    |
// |              we     - write enable                                   |
// |              waddr  - write address                                  |
// |              wdata  - write data                                     |
// |              raddr  - read address (combinational read)              |
// |              rdata  - read data                                      |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module ma_sample_buf #(
  parameter  int DATA_W = 10,
  parameter  int DEPTH  = 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read happens before a same-cycle write lands, which is what the
  // eviction logic relies on.
  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/moving_average_rs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : moving_average_rs                                       |
// | Purpose    : Streaming moving average over a power-of-two window     |
// |              N = 2^p (p <= MAX_POW), with optional half-up rounding. |
// |              A circular sample buffer supplies the evicted sample so |
// |              the running sum is updated in one add/subtract.         |
// | Ports      : clk       - rising-edge clock                           |
// |              rst_n     - asynchronous active-low reset               |
// |              in_valid  - sample strobe                               |
// |              in_data   - unsigned sample                             |
// |              in_ready  - high when a sample can be accepted          |
// |              win_sel   - window exponent p (clamped to MAX_POW)      |
// |              round_en  - 1 round half-up, 0 truncate                 |
// |              clear     - synchronous restart request                 |
// |              out_valid - one-cycle pulse per new average             |
// |              out_data  - current average, held between pulses        |
// |              primed    - N samples accepted since last clear/reset   |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module moving_average_rs
  import moving_avg_pkg::*;
#(
  parameter  int DATA_W  = 10,
  parameter  int MAX_POW = 3,
  localparam int WSEL_W  = $clog2(MAX_POW + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [WSEL_W-1:0] win_sel,
  input  logic              round_en,
  input  logic              clear,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              primed
);

  localparam int DEPTH = 1 << MAX_POW;
  localparam int SUM_W = sum_width(DATA_W, MAX_POW);
  localparam int RND_W = SUM_W + 1;
  localparam int CNT_W = MAX_POW + 1;

  // Registered state
  state_e              state_q;
  logic [MAX_POW-1:0]  sweep_q;
  logic [MAX_POW-1:0]  wp_q;
  logic [SUM_W-1:0]    sum_q;
  logic [CNT_W-1:0]    fill_q;
  logic [WSEL_W-1:0]   p_lat_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                primed_q;

  // Next-state / datapath values
  logic [WSEL_W-1:0]   p_sel;
  logic                accept;
  logic [CNT_W-1:0]    win_n;
  logic [MAX_POW-1:0]  rd_addr;
  logic [DATA_W-1:0]   old_sample;
  logic [SUM_W-1:0]    sum_d;
  logic [RND_W-1:0]    rnd_term;
  logic [RND_W-1:0]    sum_rnd;
  logic [DATA_W-1:0]   out_data_d;
  logic [CNT_W-1:0]    fill_d;
  logic                primed_d;
  logic                buf_we;
  logic [MAX_POW-1:0]  buf_waddr;
  logic [DATA_W-1:0]   buf_wdata;

  assign p_sel = (int'(win_sel) > MAX_POW) ? WSEL_W'(MAX_POW) : win_sel;

  assign in_ready  = (state_q == RUN);
  assign accept    = in_valid && in_ready && !clear;

  // Window length 2^p. Its low MAX_POW bits give the eviction distance;
  // for p = MAX_POW that distance is 0 mod DEPTH, i.e. the entry at wp.
  assign win_n   = CNT_W'(1) << p_lat_q;
  assign rd_addr = wp_q - win_n[MAX_POW-1:0];

  always_comb begin
    sum_d    = sum_q + SUM_W'(in_data) - SUM_W'(old_sample);
    rnd_term = '0;
    if (round_en && (p_lat_q != '0)) begin
      rnd_term = RND_W'(1) << (p_lat_q - 1'b1);
    end
    // One extra bit keeps the rounding add exact; the shifted result is
    // bounded by 2^DATA_W-1 so the truncating cast loses nothing.
    sum_rnd    = {1'b0, sum_d} + rnd_term;
    out_data_d = DATA_W'(sum_rnd >> p_lat_q);
    fill_d     = (fill_q == win_n) ? fill_q : fill_q + 1'b1;
    primed_d   = (fill_d == win_n);
  end

  // The sweep owns the write port during CLR; accepted samples own it in RUN.
  always_comb begin
    buf_we    = 1'b0;
    buf_waddr = wp_q;
    buf_wdata = in_data;
    if (state_q == CLR) begin
      buf_we    = 1'b1;
      buf_waddr = sweep_q;
      buf_wdata = '0;
    end else if (accept) begin
      buf_we    = 1'b1;
    end
  end

  ma_sample_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (buf_wdata),
    .raddr (rd_addr),
    .rdata (old_sample)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLR;
      sweep_q     <= '0;
      wp_q        <= '0;
      sum_q       <= '0;
      fill_q      <= '0;
      p_lat_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      primed_q    <= 1'b0;
    end else if (clear) begin
      // Restart wins over a simultaneous sample, which is dropped.
      state_q     <= CLR;
      sweep_q     <= '0;
      wp_q        <= '0;
      sum_q       <= '0;
      fill_q      <= '0;
      p_lat_q     <= p_sel;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      primed_q    <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (state_q == CLR) begin
        // The window exponent keeps tracking win_sel through the sweep so
        // that the window chosen before reset release takes effect; it is
        // frozen once RUN is entered.
        p_lat_q <= p_sel;
        sweep_q <= sweep_q + 1'b1;
        if (sweep_q == '1) begin
          state_q <= RUN;
        end
      end else if (accept) begin
        sum_q       <= sum_d;
        wp_q        <= wp_q + 1'b1;
        fill_q      <= fill_d;
        primed_q    <= primed_d;
        out_data_q  <= out_data_d;
        out_valid_q <= 1'b1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign primed    = primed_q;

endmodule
`default_nettype wire

// File: tb/tb_moving_average_rs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : tb_moving_average_rs                                    |
// | Purpose    : Self-checking bench for moving_average_rs against a     |
// |              history-queue reference model (window mean of the last  |
// |              N accepted samples, zero-filled).                       |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module tb_moving_average_rs;

  localparam int DATA_W  = 10;
  localparam int MAX_POW = 3;

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data  = '0;
  logic [1:0]        win_sel  = 2'd0;
  logic              round_en = 1'b0;
  logic              clear    = 1'b0;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              primed;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int hist[$];
  int mp       = 0;
  int last_avg = 0;

  moving_average_rs #(
    .DATA_W  (DATA_W),
    .MAX_POW (MAX_POW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .win_sel   (win_sel),
    .round_en  (round_en),
    .clear     (clear),
    .out_valid (out_valid),
    .out_data  (out_data),
    .primed    (primed)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_clear(input int p);
    hist.delete();
    mp       = p;
    last_avg = 0;
  endfunction

  // Mean of the last 2^mp accepted samples, missing history counts as zero.
  function automatic int model_avg(input bit rnd);
    int n;
    int s;
    int idx;
    n = 1 << mp;
    s = 0;
    for (int i = 0; i < n; i++) begin
      idx = hist.size() - 1 - i;
      if (idx >= 0) s += hist[idx];
    end
    if (rnd && mp > 0) s += 1 << (mp - 1);
    return s / n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x, input string tag);
    in_valid = 1'b1;
    in_data  = x[DATA_W-1:0];
    tick();
    hist.push_back(x);
    last_avg = model_avg(round_en);
    check_val({tag, "_valid"},  32'(out_valid), 1);
    check_val({tag, "_data"},   32'(out_data),  last_avg);
    check_val({tag, "_primed"}, 32'(primed),    (hist.size() >= (1 << mp)) ? 1 : 0);
  endtask

  task automatic idle_check(input string tag);
    in_valid = 1'b0;
    tick();
    check_val({tag, "_idle_valid"}, 32'(out_valid), 0);
    check_val({tag, "_idle_hold"},  32'(out_data),  last_avg);
  endtask

  // Counts clock edges until in_ready rises, bounded.
  task automatic wait_ready(input string tag, input int expected);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    check_val({tag, "_ready_cycles"}, n, expected);
  endtask

  task automatic clear_run(input int p, input bit with_sample, input string tag);
    win_sel  = p[1:0];
    clear    = 1'b1;
    in_valid = with_sample;
    in_data  = 10'd99;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    check_val({tag, "_clr_valid"},  32'(out_valid), 0);
    check_val({tag, "_clr_data"},   32'(out_data),  0);
    check_val({tag, "_clr_primed"}, 32'(primed),    0);
    check_val({tag, "_clr_ready"},  32'(in_ready),  0);
    model_clear(p);
    wait_ready(tag, 8);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset and release
    win_sel = 2'd2;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check_val("rst_ready",  32'(in_ready),  0);
    check_val("rst_valid",  32'(out_valid), 0);
    check_val("rst_data",   32'(out_data),  0);
    check_val("rst_primed", 32'(primed),    0);
    rst_n = 1'b1;
    model_clear(2);
    wait_ready("rst_release", 8);
    check_val("rel_data",   32'(out_data), 0);
    check_val("rel_primed", 32'(primed),   0);

    // Window 4, truncation then rounding
    round_en = 1'b0;
    for (int i = 1; i <= 4; i++) send(i, "w4_trunc");
    check_val("w4_trunc_last", 32'(out_data), 2);
    idle_check("w4_trunc");
    clear_run(2, 1'b0, "w4_rnd");
    round_en = 1'b1;
    for (int i = 1; i <= 4; i++) send(i, "w4_rnd");
    check_val("w4_rnd_last", 32'(out_data), 3);
    idle_check("w4_rnd");

    // Eviction across the window
    clear_run(2, 1'b0, "evict");
    round_en = 1'b0;
    for (int i = 1; i <= 5; i++) send(4 * i, "evict");
    check_val("evict_last", 32'(out_data), 14);
    idle_check("evict");

    // Full-scale back-to-back at maximum window, two pointer wraps
    clear_run(3, 1'b0, "full");
    round_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(1023, "full");
      if (i >= 7) check_val("full_max", 32'(out_data), 1023);
    end
    idle_check("full");

    // Clear with a simultaneous sample and a window change
    clear_run(2, 1'b0, "drop_pre");
    round_en = 1'b0;
    for (int i = 0; i < 5; i++) send($urandom_range(0, 1023), "drop_pre");
    clear_run(1, 1'b1, "drop");
    send(6, "drop_a");
    check_val("drop_a_const", 32'(out_data), 3);
    send(10, "drop_b");
    check_val("drop_b_const", 32'(out_data), 8);
    idle_check("drop");

    // Clear during the sweep restarts it
    win_sel = 2'd2;
    clear   = 1'b1;
    tick();
    clear   = 1'b0;
    repeat (3) tick();
    check_val("restart_mid_ready", 32'(in_ready), 0);
    clear_run(2, 1'b0, "restart");

    // Asynchronous reset mid-stream
    send(1000, "arst_pre");
    rst_n = 1'b0;
    #1;
    check_val("arst_ready",  32'(in_ready),  0);
    check_val("arst_valid",  32'(out_valid), 0);
    check_val("arst_data",   32'(out_data),  0);
    check_val("arst_primed", 32'(primed),    0);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    model_clear(int'(win_sel));
    wait_ready("arst_release", 8);
    send(100, "arst_post");
    send(200, "arst_post");

    // Randomised traffic with random window, rounding and restarts
    for (int r = 0; r < 6; r++) begin
      clear_run(int'($urandom_range(0, 3)), 1'b0, "rnd_start");
      for (int c = 0; c < 40; c++) begin
        int sel;
        sel = int'($urandom_range(0, 19));
        if (sel == 0) begin
          clear_run(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rnd_clear");
        end else if (sel < 6) begin
          idle_check("rnd");
        end else begin
          round_en = 1'($urandom_range(0, 1));
          send(int'($urandom_range(0, 1023)), "rnd");
        end
      end
      idle_check("rnd_end");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
